// File: rtl/logs_pwm_demod.sv
// PWM-to-sample demodulator: synchronises a 1-bit PWM stream, counts ones over a 2^DEC_LOG2 window
// and hands each saturated count out through a valid/ready register. Optional macro LOGS_DEMOD_SMOOTH_EN adds a two-tap average.
module logs_pwm_demod #(
    parameter int DEC_LOG2 = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                snd_in,
    output logic [DEC_LOG2-1:0] sample_out,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun
);

    logic                sync1;
    logic                sync2;
    logic [DEC_LOG2-1:0] wcnt;
    logic [DEC_LOG2:0]   acc;
    logic [DEC_LOG2:0]   total;
    logic [DEC_LOG2-1:0] cnt;
    logic [DEC_LOG2-1:0] load_val;
    logic                win_end;

    assign win_end = (wcnt == {DEC_LOG2{1'b1}});
    assign total   = acc + {{DEC_LOG2{1'b0}}, sync2};
    // total only reaches bit DEC_LOG2 for a window of all ones; clamp that to all-ones
    assign cnt     = total[DEC_LOG2] ? {DEC_LOG2{1'b1}} : total[DEC_LOG2-1:0];

`ifdef LOGS_DEMOD_SMOOTH_EN
    logic [DEC_LOG2-1:0] prev;

    // (cnt + prev + 1) >> 1 rewritten so the sum never needs an extra bit
    assign load_val = (cnt >> 1) + (prev >> 1) + DEC_LOG2'(cnt[0] | prev[0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= '0;
        end else if (win_end) begin
            prev <= cnt;
        end
    end
`else
    assign load_val = cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            wcnt         <= '0;
            acc          <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sync1 <= snd_in;
            sync2 <= sync1;
            wcnt  <= wcnt + DEC_LOG2'(1);
            if (win_end) begin
                acc          <= '0;
                sample_out   <= load_val;
                sample_valid <= 1'b1;
                if (sample_valid && !sample_ready) begin
                    overrun <= 1'b1;
                end
            end else begin
                acc <= total;
                if (sample_valid && sample_ready) begin
                    sample_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/logs_pwm_demod.md
# logs_pwm_demod

Receive-side counterpart of the logistic-map sonifier: recovers multi-bit audio samples from the 1-bit PWM `snd` stream produced by the mixer. It synchronises the input, counts ones over a fixed power-of-two window (integrate-and-dump decimation), and presents each window's result through a valid/ready handshake with overrun detection. It is used on-chip for loopback self-test and in benches as a scoring monitor for the sonifier output.

## Interface
Parameters:
- `DEC_LOG2`, default 8: log2 of the decimation window length, W = 2^DEC_LOG2 clocks. Legal range 2..16.

Ports:
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `snd_in` input 1: PWM audio. May be asynchronous to `clk`.
- `sample_out` output DEC_LOG2: demodulated sample, unsigned.
- `sample_valid` output 1: `sample_out` holds an unconsumed sample.
- `sample_ready` input 1: consumer accepts the sample in any cycle where valid and ready are both 1.
- `overrun` output 1: sticky. Set when an unconsumed sample is overwritten.

## Operation
- Synchroniser: two-flop chain. The synchronised bit s(k) equals `snd_in` sampled two edges earlier. s = 0 for the first two cycles after reset.
- Window counter `wcnt`, DEC_LOG2 bits:
  - Cycle k after reset release has `wcnt` = k mod W. It wraps naturally from W-1 to 0.
- Accumulator `acc`, DEC_LOG2+1 bits:
  - When `wcnt` != W-1: `acc` <= `acc` + s.
  - When `wcnt` == W-1: compute `total` = `acc` + s, which ranges 0..W. Then `acc` <= 0.
- Saturation: `cnt` = min(`total`, W-1), so a full window of ones yields all-ones.
- Load on window end, in the cycle where `wcnt` == W-1:
  - `sample_out` <= `cnt`. With `LOGS_DEMOD_SMOOTH_EN`, the smoothed value is loaded instead (see Configuration).
  - `sample_valid` <= 1.
  - If `sample_valid` == 1 and `sample_ready` == 0 in that cycle, `overrun` <= 1. The old sample is lost and the newest one wins.
- Consume: valid & ready with no window end in the same cycle gives `sample_valid` <= 0. `sample_out` holds its value.
- Simultaneous consume and window end: the new sample loads, `sample_valid` stays 1, and `overrun` is not set.
- `overrun` clears only on reset.
- Reset mid-window clears all of the following: sync flops, `wcnt`, `acc`, `sample_out`, `sample_valid`, `overrun`, and the smoothing history. The partial window is discarded.

## Timing
- All state changes on the rising edge of `clk`. Outputs are registered, with no combinational path from `sample_ready` to any output.
- Reset values: `sample_out` = 0, `sample_valid` = 0, `overrun` = 0.
- Let cycle 0 be the first cycle with `reset` = 0.
  - `sample_valid` first rises in cycle W, carrying window cycles 0..W-1.
  - After that, a new sample arrives every W cycles, in cycles nW.
- Latency from `snd_in` to its contribution to a sample: 2 cycles of synchronisation plus up to W cycles of window alignment.
- A consumer asserting ready continuously sees `sample_valid` high for exactly one cycle per window.

## Configuration
- Macro: `LOGS_DEMOD_SMOOTH_EN`.
- Defined: a second-stage two-tap average is applied.
  - Loaded sample = (`cnt` + `prev` + 1) >> 1, computed at DEC_LOG2+1 bits.
  - `prev` <= `cnt` on each window end. `prev` resets to 0.
  - Timing and handshake are unchanged.
- Undefined: the loaded sample = `cnt`, and the `prev` register does not exist.

## Test plan
- **Constant one.** `DEC_LOG2`=4, `snd_in`=1, ready=1 → first sample at cycle 16 with value 14 (two sync zeros). Every later sample is 15 (saturated from 16). `overrun`=0.
- **Constant zero, and half-duty square.**
  - `snd_in`=0 → every sample is 0.
  - `snd_in` toggling every cycle, `DEC_LOG2`=4 → steady-state samples are 8.
- **Backpressure.** ready=0 for cycles 0..50, data ramping → `sample_valid` is 1 from cycle 16 onward. `sample_out` updates at cycles 32 and 48. `overrun` rises at cycle 32 and stays 1 after ready=1 drains.
- **Simultaneous events.** ready pulsed exactly at the window-end cycle while valid=1 → the new sample loads, valid stays 1, `overrun` stays 0.
- **Reset mid-window.** Assert reset at cycle 23 for one cycle → all outputs are 0 the next cycle. The next valid sample arrives 16 cycles after release, with the count restarted (14 for constant one).
- **Smoothing.** With `LOGS_DEMOD_SMOOTH_EN` and `DEC_LOG2`=4, a step of 0→1 at cycle 0 → samples 7, 15, 15. The first value is (14+0+1)>>1; the second is (15+14+1)>>1. Without the macro, the samples are 14, 15, 15.
